mul_div_seq: RTL
================

Name: mul_div_seq

Overview:
Multi-cycle sequencer for the 8051 MUL AB and DIV AB instructions. It serves the reserved ALU opcode 4'hf slot of the processing stage, which the single-cycle ALU does not implement. The block accepts operands A and B plus the current PSW and iterates one bit per cycle (shift-add multiply, restoring divide). It returns the new A, B and PSW with a one-cycle done pulse. The CPU control unit stalls on busy.

Parameters:
DATA_W, 8, operand width; only 8 is supported for 8051 semantics.
CY_BIT, 7, PSW carry bit index.
OV_BIT, 2, PSW overflow bit index.
P_BIT, 0, PSW parity bit index.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
op  in  1  0 = MUL AB, 1 = DIV AB; sampled with start.
a_in  in  8  accumulator operand.
b_in  in  8  B register operand.
psw_in  in  8  current PSW; sampled with start.
flush  in  1  synchronous abort (pipeline flush or interrupt entry).
busy  out  1  high from the cycle after accept until the done cycle, inclusive.
done  out  1  one-cycle pulse; results valid.
ans_a  out  8  new A: product low byte or quotient.
ans_b  out  8  new B: product high byte or remainder.
psw_out  out  8  new PSW.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: state = IDLE, busy = 0, done = 0, ans_a = 0, ans_b = 0, psw_out = 0, iteration counter = 0.
- States and transitions:
  - IDLE: on start, latch op, a_in, b_in and psw_in, clear the counter, then go to MUL or DIV.
  - DIV with b_in == 0 at accept: go straight to DONE.
  - MUL and DIV: one iteration per cycle, 3-bit counter 0..7; after the counter reaches 7, go to DONE.
  - DONE: assert done for one cycle, then return to IDLE.
- Latency: start accepted at cycle T; iterations run T+1..T+8; done at T+9. Divide-by-zero: done at T+1.
- busy is combinational from state: high in MUL, DIV and DONE.
- MUL: 16-bit shift-add of the latched operands. Result: ans_a = product[7:0], ans_b = product[15:8].
- DIV: restoring division, MSB first, 9-bit partial remainder. Result: ans_a = quotient, ans_b = remainder.
- Divide by zero: ans_a = latched A and ans_b = latched B (unchanged).
- PSW rules:
  - psw_out = latched psw_in, except CY_BIT = 0.
  - MUL: OV_BIT = (product > 255).
  - DIV: OV_BIT = (divisor == 0).
  - P_BIT = ^ans_a.
- ans_a, ans_b and psw_out update only on the cycle that enters DONE. They hold until the next completed operation.
- start while busy: ignored. No queueing; the requester must wait for done.
- start in the DONE cycle: ignored. The earliest acceptance is the IDLE cycle after done.
- flush: in any state, next state = IDLE with no done pulse. Output registers keep their previous values. flush has priority over start in IDLE.
- rst_n low mid-operation: immediate return to the reset values; the operation is lost.

Decomposition:
- Shared package mcu51_pkg:
  - state encoding for IDLE, MUL, DIV, DONE;
  - PSW bit index constants CY, AC, F0, RS1, RS0, OV, P;
  - ALU_OP_EXT = 4'hf.
- One sub-module is natural: mul_div_step. It is a combinational single iteration: given op, partial accumulator/remainder, shift register and multiplicand/divisor, it produces the next values.
- The FSM, counter and output registers stay in mul_div_seq.

Test Plan:
- MUL, a_in = 12, b_in = 13, psw_in = 0x80 -> done at T+9 only; ans_a = 0x9C, ans_b = 0x00, psw_out = 0x00 (CY cleared, OV 0, P 0).
- MUL, a_in = 0xFF, b_in = 0xFF -> ans_a = 0x01, ans_b = 0xFE, OV = 1, CY = 0, P = 1.
- DIV, a_in = 200, b_in = 7 -> ans_a = 0x1C, ans_b = 0x04, OV = 0, P = 1. DIV, a_in = 5, b_in = 9 -> ans_a = 0, ans_b = 5.
- DIV, a_in = 0x55, b_in = 0 -> done at T+1; ans_a = 0x55, ans_b = 0x00, OV = 1, CY = 0.
- start pulsed at T+3 during MUL with different operands -> ignored; first result unchanged; a single done at T+9; busy high T+1..T+9.
- flush at T+4 -> no done, outputs keep their prior values, back to IDLE at T+5. rst_n low at T+5 of a new operation -> all outputs 0 immediately. A new start afterwards completes normally.

Source files
------------

// File: rtl/mcu51_pkg.sv
// Shared 8051 core constants: sequencer state codes,
// PSW bit positions and the extended ALU opcode slot.
package mcu51_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int PSW_CY  = 7;
  localparam int PSW_AC  = 6;
  localparam int PSW_F0  = 5;
  localparam int PSW_RS1 = 4;
  localparam int PSW_RS0 = 3;
  localparam int PSW_OV  = 2;
  localparam int PSW_P   = 0;

  localparam logic [3:0] ALU_OP_EXT = 4'hf;

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration of shift-add multiply
// (LSB first) or restoring divide (MSB first).
module mul_div_step (
  input  logic       op_i,
  input  logic [8:0] acc_i,
  input  logic [7:0] sh_i,
  input  logic [7:0] opd_i,
  output logic [8:0] acc_o,
  output logic [7:0] sh_o
);

  logic [8:0] sum;
  logic [8:0] shl;
  logic [8:0] diff;

  always_comb begin
    sum   = {1'b0, acc_i[7:0]} + {1'b0, opd_i};
    shl   = {acc_i[7:0], sh_i[7]};
    diff  = shl - {1'b0, opd_i};
    acc_o = acc_i;
    sh_o  = sh_i;
    if (op_i) begin
      if (shl >= {1'b0, opd_i}) begin
        acc_o = diff;
        sh_o  = {sh_i[6:0], 1'b1};
      end else begin
        acc_o = shl;
        sh_o  = {sh_i[6:0], 1'b0};
      end
    end else begin
      // {acc, sh} is the 16-bit product register, shifted right
      if (sh_i[0]) begin
        acc_o = {1'b0, sum[8:1]};
        sh_o  = {sum[0], sh_i[7:1]};
      end else begin
        acc_o = {1'b0, acc_i[8:1]};
        sh_o  = {acc_i[0], sh_i[7:1]};
      end
    end
  end

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle MUL AB / DIV AB sequencer for the
// reserved ALU opcode slot; stalls the core via busy.
module mul_div_seq
  import mcu51_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CY_BIT = PSW_CY,
  parameter int OV_BIT = PSW_OV,
  parameter int P_BIT  = PSW_P
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] psw_in,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ans_a,
  output logic [DATA_W-1:0] ans_b,
  output logic [DATA_W-1:0] psw_out
);

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       op_q, op_d;
  logic [8:0] acc_q, acc_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] opd_q, opd_d;
  logic [7:0] psw_q, psw_d;
  logic [7:0] ans_a_q, ans_a_d;
  logic [7:0] ans_b_q, ans_b_d;
  logic [7:0] pswo_q, pswo_d;

  logic [8:0] acc_n;
  logic [7:0] sh_n;

  function automatic logic [7:0] mk_psw(
    input logic [7:0] p,
    input logic       ov,
    input logic [7:0] a
  );
    logic [7:0] r;
    r         = p;
    r[CY_BIT] = 1'b0;
    r[OV_BIT] = ov;
    r[P_BIT]  = ^a;
    return r;
  endfunction

  mul_div_step u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .sh_i  (sh_q),
    .opd_i (opd_q),
    .acc_o (acc_n),
    .sh_o  (sh_n)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opd_d   = opd_q;
    psw_d   = psw_q;
    ans_a_d = ans_a_q;
    ans_b_d = ans_b_q;
    pswo_d  = pswo_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d  = op;
            sh_d  = a_in;
            opd_d = b_in;
            psw_d = psw_in;
            acc_d = '0;
            cnt_d = '0;
            if (op && b_in == '0) begin
              state_d = ST_DONE;
              ans_a_d = a_in;
              ans_b_d = b_in;
              pswo_d  = mk_psw(psw_in, 1'b1, a_in);
            end else begin
              state_d = op ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          acc_d = acc_n;
          sh_d  = sh_n;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            // sh holds product low / quotient, acc high / remainder
            state_d = ST_DONE;
            ans_a_d = sh_n;
            ans_b_d = acc_n[7:0];
            pswo_d  = mk_psw(psw_q,
                             ~op_q & (|acc_n[7:0]),
                             sh_n);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      sh_q    <= '0;
      opd_q   <= '0;
      psw_q   <= '0;
      ans_a_q <= '0;
      ans_b_q <= '0;
      pswo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opd_q   <= opd_d;
      psw_q   <= psw_d;
      ans_a_q <= ans_a_d;
      ans_b_q <= ans_b_d;
      pswo_q  <= pswo_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign ans_a   = ans_a_q;
  assign ans_b   = ans_b_q;
  assign psw_out = pswo_q;

endmodule
